// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, state encoding and strobe timer helper for the SRAM sequencer
package sram_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4,
    ST_TURN   = 3'd5
  } state_t;

  // The timer counts down to zero inclusive, so a strobe of N cycles loads N-1.
  function automatic logic [WAIT_CNT_W-1:0] strobe_load(input int wait_cycles);
    return WAIT_CNT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// rtl/sram_wait_timer.sv - loadable down-counter with zero flag that times the strobe pulse
module sram_wait_timer
  import sram_pkg::*;
(
  input  logic                  clock,
  input  logic                  clear_b,
  input  logic                  load,
  input  logic                  en,
  input  logic [WAIT_CNT_W-1:0] load_value,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] count;

  // Load has priority; the count parks at zero once it gets there.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - WAIT_CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - CPU request to async SRAM strobe sequencer (option: SRAM_ACCESS_CTRL_TURNAROUND_EN)
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2   // strobe width in cycles, 1..15
) (
  input  logic              clock,
  input  logic              clear_b,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              Cs_b,
  output logic              We_b,
  output logic              Oe_b,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] IO
);

  localparam logic [WAIT_CNT_W-1:0] STROBE_LOAD = strobe_load(WAIT_CYCLES);

  state_t            state;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              io_oe;
  logic              timer_load;
  logic              timer_en;
  logic              timer_zero;
`ifdef SRAM_ACCESS_CTRL_TURNAROUND_EN
  logic              prev_rd;
`endif

  // Timer is armed during SETUP so it holds WAIT_CYCLES-1 on the first STROBE cycle.
  assign timer_load = (state == ST_SETUP);
  assign timer_en   = (state == ST_STROBE);

  sram_wait_timer u_wait_timer (
    .clock      (clock),
    .clear_b    (clear_b),
    .load       (timer_load),
    .en         (timer_en),
    .load_value (STROBE_LOAD),
    .zero       (timer_zero)
  );

  // The controller only drives the bus from SETUP through HOLD of a write.
  assign IO = io_oe ? wdata_q : {DATA_W{1'bz}};

  // Sequencer: every output is registered and set on the edge entering the state it belongs to.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      state   <= ST_IDLE;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      io_oe   <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Cs_b    <= 1'b1;
      We_b    <= 1'b1;
      Oe_b    <= 1'b1;
      Address <= '0;
`ifdef SRAM_ACCESS_CTRL_TURNAROUND_EN
      prev_rd <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            wr_q    <= wr;
            wdata_q <= wdata;
            Address <= addr;
            busy    <= 1'b1;
`ifdef SRAM_ACCESS_CTRL_TURNAROUND_EN
            prev_rd <= ~wr;
            if (wr && prev_rd) begin
              // One dead cycle lets the SRAM release IO before the controller drives it.
              state <= ST_TURN;
            end else begin
              state <= ST_SETUP;
              Cs_b  <= 1'b0;
              io_oe <= wr;
            end
`else
            state <= ST_SETUP;
            Cs_b  <= 1'b0;
            io_oe <= wr;
`endif
          end
        end
        ST_TURN: begin
          state <= ST_SETUP;
          Cs_b  <= 1'b0;
          io_oe <= wr_q;
        end
        ST_SETUP: begin
          state <= ST_STROBE;
          We_b  <= ~wr_q;
          Oe_b  <= wr_q;
        end
        ST_STROBE: begin
          if (timer_zero) begin
            state <= ST_HOLD;
            We_b  <= 1'b1;
            Oe_b  <= 1'b1;
            if (!wr_q) begin
              rdata <= IO;
            end
          end
        end
        ST_HOLD: begin
          state <= ST_DONE;
          Cs_b  <= 1'b1;
          io_oe <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          Cs_b  <= 1'b1;
          We_b  <= 1'b1;
          Oe_b  <= 1'b1;
          io_oe <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed vector bench with async SRAM model for sram_access_ctrl
module tb_sram_access_ctrl;

  localparam int W = 2;

  logic        clock = 1'b0;
  logic        clear_b = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        Cs_b;
  logic        We_b;
  logic        Oe_b;
  logic [8:0]  Address;
  wire  [31:0] io_bus;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] mem [0:511];
  logic        mem_drive;

  sram_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clock   (clock),
    .clear_b (clear_b),
    .req     (req),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .Cs_b    (Cs_b),
    .We_b    (We_b),
    .Oe_b    (Oe_b),
    .Address (Address),
    .IO      (io_bus)
  );

  always #5 clock = ~clock;

  // Async SRAM model: reads while selected with Oe_b low, writes on the rising We_b.
  assign mem_drive = !Cs_b && !Oe_b && We_b;
  assign io_bus = mem_drive ? mem[Address] : 32'bz;

  always @(posedge We_b) begin
    if (!Cs_b && clear_b) mem[Address] = io_bus;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Invariant monitor.
  logic        prev_we_low = 1'b0;
  logic [8:0]  prev_addr = '0;
  logic [31:0] prev_io = '0;
  always @(negedge clock) begin
    if (clear_b) begin
      check("we_oe_overlap", 32'(!(!We_b && !Oe_b)), 32'd1);
      if (prev_we_low && !We_b) begin
        check("addr_stable_we", 32'(Address), 32'(prev_addr));
        check("io_stable_we", io_bus, prev_io);
      end
      prev_we_low = !We_b;
      prev_addr   = Address;
      prev_io     = io_bus;
    end else begin
      prev_we_low = 1'b0;
    end
  end

  typedef struct {
    logic        w;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic do_access(input logic w, input logic [8:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input int exp_lat, input logic turn);
    int n;
    int strobe_n;
    logic seen;
    @(negedge clock);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clock);
    #1 req = 1'b0;
    n = 0; strobe_n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clock);
      n++;
      if (w && !We_b) strobe_n++;
      if (!w && !Oe_b) strobe_n++;
      if (n == 1) begin
        check("busy_after_accept", 32'(busy), 32'd1);
        check("first_cs_b", 32'(Cs_b), turn ? 32'd1 : 32'd0);
        check("first_strobes", 32'({We_b, Oe_b}), 32'd3);
        if (w && !turn) check("setup_io", io_bus, d);
      end
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", 32'(busy), 32'd1);
        check("rdata_at_done", rdata, exp_rd);
      end
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("strobe_width", 32'(strobe_n), 32'(W));
    @(negedge clock);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_pulse_len", 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
  end

  initial begin
    int turn_extra;
    logic prev_read;
    int cyc;
    int nd;
    int dt [3];
    logic cs_hist [0:127];
    logic busy_hist [0:127];

`ifdef SRAM_ACCESS_CTRL_TURNAROUND_EN
    turn_extra = 1;
`else
    turn_extra = 0;
`endif

    vecs[0] = '{1'b1, 9'h1A5, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b0, 9'h1A5, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 9'h000, 32'h00000001, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 9'h1FF, 32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 9'h000, 32'h00000000, 32'h00000001};
    vecs[5] = '{1'b0, 9'h1FF, 32'h00000000, 32'hFFFFFFFF};
    vecs[6] = '{1'b1, 9'h0A5, 32'h12345678, 32'hFFFFFFFF};
    vecs[7] = '{1'b0, 9'h1A5, 32'h00000000, 32'hDEADBEEF};
    vecs[8] = '{1'b0, 9'h0A5, 32'h00000000, 32'h12345678};

    // Reset state.
    #12;
    check("rst_cs_b", 32'(Cs_b), 32'd1);
    check("rst_we_oe", 32'({We_b, Oe_b}), 32'd3);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_address", 32'(Address), 32'd0);
    @(negedge clock);
    clear_b = 1'b1;

    prev_read = 1'b0;
    for (int i = 0; i < 9; i++) begin
      logic turn;
      turn = prev_read && vecs[i].w && (turn_extra == 1);
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rdata,
                W + 3 + (turn ? 1 : 0), turn);
      prev_read = !vecs[i].w;
      if (i == 0) check("mem_1a5", mem[9'h1A5], 32'hDEADBEEF);
    end
    check("mem_000", mem[9'h000], 32'h00000001);
    check("mem_1ff", mem[9'h1FF], 32'hFFFFFFFF);

    // Back-to-back reads with req held high.
    @(negedge clock);
    req = 1'b1; wr = 1'b0; addr = 9'h1FF;
    cyc = 0; nd = 0;
    while (nd < 3 && cyc < 120) begin
      @(negedge clock);
      cyc++;
      cs_hist[cyc]   = Cs_b;
      busy_hist[cyc] = busy;
      if (done) begin
        dt[nd] = cyc;
        nd++;
        if (nd == 3) req = 1'b0;
      end
    end
    check("b2b_done_count", 32'(nd), 32'd3);
    if (nd == 3) begin
      check("b2b_spacing_1", 32'(dt[1] - dt[0]), 32'(W + 4));
      check("b2b_spacing_2", 32'(dt[2] - dt[1]), 32'(W + 4));
      check("b2b_gap_busy", 32'(busy_hist[dt[0] + 1]), 32'd0);
      check("b2b_gap_cs", 32'(cs_hist[dt[0] + 1]), 32'd1);
      check("b2b_setup_cs", 32'(cs_hist[dt[0] + 2]), 32'd0);
      check("b2b_rdata", rdata, 32'hFFFFFFFF);
    end
    repeat (3) @(negedge clock);
    check("b2b_no_extra", 32'(busy), 32'd0);

    // Reset in the middle of a write strobe.
    @(negedge clock);
    req = 1'b1; wr = 1'b1; addr = 9'h0A5; wdata = 32'hA5A5A5A5;
    @(posedge clock);
    #1 req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("mid_strobe_we", 32'(We_b), 32'd0);
    clear_b = 1'b0;
    #1;
    check("abort_strobes", 32'({Cs_b, We_b, Oe_b}), 32'd7);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_address", 32'(Address), 32'd0);
    #20;
    @(negedge clock);
    clear_b = 1'b1;
    repeat (2) @(negedge clock);
    check("post_abort_idle", 32'({busy, Cs_b}), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
